alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath/immediate width (32 or 64).
REQ-002 SHALL have parameter CNT_W, default 16, illegal-instruction counter width.
REQ-003 SHALL have ports:
  - clk  input  1  rising-edge clock.
  - rst_n  input  1  asynchronous, active-low reset.
  - flush  input  1  discard all buffered entries.
  - in_valid  input  1  instruction offered.
  - in_ready  output  1  stage can accept.
  - in_instr  input  32  RV32 instruction word.
  - out_valid  output  1  decoded entry available.
  - out_ready  input  1  consumer accepts.
  - out_aluop  output  5  ALU op code.
  - out_asel  output  2  operand A: 00 rs1, 01 pc, 10 zero.
  - out_bsel_imm  output  1  operand B is immediate.
  - out_imm  output  XLEN  sign-extended immediate.
  - out_br_inv  output  1  branch unit inverts ALU result (BNE/BGE/BGEU).
  - out_illegal  output  1  entry is an illegal encoding.
  - illegal_cnt  output  CNT_W  saturating count of accepted illegal entries.

Function
REQ-004 ALU codes SHALL be: ADD 0, SUB 1, XOR 2, OR 3, AND 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9; M codes MUL 10 .. REMU 17 (order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-005 Decode SHALL be:
  - R-type: funct3 selects the op; funct7[5] selects SUB/SRA.
  - I-type: funct3 selects the op; SRAI by funct7[5].
  - BRANCH: BEQ/BNE SUB, BLT/BGE SLT, BLTU/BGEU SLTU.
  - LOAD, STORE, JALR, LUI, AUIPC, JAL: ADD.
REQ-006 Operand selection SHALL be: LUI asel=zero; AUIPC/JAL asel=pc; all others rs1; bsel_imm=1 for every opcode except R-type and BRANCH.
REQ-007 Immediate SHALL be the I/S/B/U/J format per opcode, sign-extended to XLEN; 0 for R-type.
REQ-008 out_illegal SHALL be 1 for:
  - unknown opcode.
  - R-type funct7 not 0000000/0100000 (0100000 legal only with funct3 000/101).
  - shift-immediate upper bits not 0000000/0100000 (XLEN=64: funct6 instead).
  - BRANCH funct3 010/011.
  Illegal entries SHALL carry aluop ADD.
REQ-009 Decode SHALL be registered: an accepted instruction appears on out_* exactly 1 cycle after acceptance when the output is free.
REQ-010 Transfers SHALL occur on a cycle where valid&&ready; out_* SHALL hold stable while out_valid&&!out_ready.
REQ-011 Buffering SHALL be a two-entry skid buffer: main + skid register; in_ready SHALL be registered, equal to !skid_valid; full throughput with out_ready held 1.
REQ-012 Output stall with main full and an input accepted SHALL capture the input into skid; on drain, skid moves to main in order, no loss or duplication.
REQ-013 flush SHALL clear both entries at the next edge (out_valid=0, in_ready=1 next cycle) and SHALL override a simultaneous input transfer (input dropped).
REQ-014 illegal_cnt SHALL increment when an illegal entry leaves via out_valid&&out_ready; saturates at all-ones; not cleared by flush.

Reset
REQ-015 rst_n low SHALL asynchronously force out_valid=0, skid empty, in_ready=1, illegal_cnt=0, out_aluop/out_asel/out_bsel_imm/out_imm/out_br_inv/out_illegal=0.
REQ-016 Reset asserted mid-stall SHALL discard both entries; first accept after deassertion SHALL behave as from idle.

Configuration
REQ-017 Macro RV32M_EXT_EN: when defined, R-type funct7=0000001 SHALL decode to MUL..REMU by funct3 and be legal; when undefined, funct7=0000001 SHALL be illegal and codes 10-17 never produced.

Structure
REQ-018 Opcode constants, ALU op codes, asel encodings and a decoded-entry struct SHALL live in package rv_alu_pkg, shared with the ALU.
REQ-019 Combinational decode SHALL be sub-module alu_decode_comb; alu_decode_stage holds only the skid buffer and counter.

Verification
REQ-020 Benches SHALL cover:
  - SUB 0x40B50533, out_ready=1 -> 1 cycle later aluop=1, asel=00, bsel_imm=0, illegal=0.
  - BGEU 0x00B57463 -> aluop=9, br_inv=1, imm=8, bsel_imm=0.
  - Back-to-back 4 instrs with out_ready low 3 cycles -> in_ready falls after 2 accepts; all 4 emerge in order.
  - flush with in_valid=1 and skid full -> next cycle out_valid=0, in_ready=1; flushed instrs never appear.
  - 0x02B50533 (MUL) -> aluop=10, illegal=0 with RV32M_EXT_EN; illegal=1 and illegal_cnt +1 without it.
  - 2^CNT_W+3 illegal words (0xFFFFFFFF) -> illegal_cnt saturates at all-ones; rst_n low mid-stream -> counter 0 immediately.

Source files
------------

// File: rtl/rv_alu_pkg.sv
// Shared RV32 decode definitions: opcodes, ALU op codes, operand-A selects and
// the decoded control struct consumed by both the decode stage and the ALU.
package rv_alu_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_XOR    = 5'd2,
    ALU_OR     = 5'd3,
    ALU_AND    = 5'd4,
    ALU_SLL    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_SLT    = 5'd8,
    ALU_SLTU   = 5'd9,
    ALU_MUL    = 5'd10,
    ALU_MULH   = 5'd11,
    ALU_MULHSU = 5'd12,
    ALU_MULHU  = 5'd13,
    ALU_DIV    = 5'd14,
    ALU_DIVU   = 5'd15,
    ALU_REM    = 5'd16,
    ALU_REMU   = 5'd17
  } alu_op_e;

  typedef enum logic [1:0] {
    ASEL_RS1  = 2'b00,
    ASEL_PC   = 2'b01,
    ASEL_ZERO = 2'b10
  } asel_e;

  typedef struct packed {
    alu_op_e aluop;
    asel_e   asel;
    logic    bsel_imm;
    logic    br_inv;
    logic    illegal;
  } dec_ctl_t;

  // Base integer op from funct3; alt picks SUB/SRA on the 000/101 slots.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  base_op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/alu_decode_comb.sv
// Purely combinational RV32 instruction decode to ALU control and immediate.
// RV32M_EXT_EN (when defined) makes funct7=0000001 R-type decode to MUL..REMU.
module alu_decode_comb
  import rv_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output dec_ctl_t        ctl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]         opc;
  logic [2:0]         f3;
  logic [6:0]         f7;
  logic               shamt_ok;
  logic signed [31:0] imm32;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7  = instr[31:25];

  // RV64 shift immediates use a 6-bit shamt, leaving funct6 as the check field.
  always_comb begin
    if (XLEN == 64)
      shamt_ok = (instr[31:26] == 6'b000000) || (instr[31:26] == 6'b010000);
    else
      shamt_ok = (f7 == 7'b0000000) || (f7 == 7'b0100000);
  end

  always_comb begin
    ctl.aluop    = ALU_ADD;
    ctl.asel     = ASEL_RS1;
    ctl.bsel_imm = 1'b0;
    ctl.br_inv   = 1'b0;
    ctl.illegal  = 1'b0;
    imm32        = '0;
    case (opc)
      OPC_OP: begin
        if (f7 == 7'b0000000)
          ctl.aluop = base_op(f3, 1'b0);
        else if (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101))
          ctl.aluop = base_op(f3, 1'b1);
`ifdef RV32M_EXT_EN
        else if (f7 == 7'b0000001)
          ctl.aluop = alu_op_e'(5'd10 + {2'b00, f3});
`endif
        else
          ctl.illegal = 1'b1;
      end
      OPC_OPIMM: begin
        ctl.bsel_imm = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:20]};
        if (f3 == 3'b001 || f3 == 3'b101) begin
          if (shamt_ok) ctl.aluop = base_op(f3, (f3 == 3'b101) && instr[30]);
          else          ctl.illegal = 1'b1;
        end else begin
          ctl.aluop = base_op(f3, 1'b0);
        end
      end
      OPC_BRANCH: begin
        imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        case (f3)
          3'b000, 3'b001: ctl.aluop = ALU_SUB;
          3'b100, 3'b101: ctl.aluop = ALU_SLT;
          3'b110, 3'b111: ctl.aluop = ALU_SLTU;
          default:        ctl.illegal = 1'b1;
        endcase
        ctl.br_inv = f3[0] && (f3 != 3'b011);
      end
      OPC_LOAD, OPC_JALR: begin
        ctl.bsel_imm = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        ctl.bsel_imm = 1'b1;
        imm32        = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_LUI: begin
        ctl.asel     = ASEL_ZERO;
        ctl.bsel_imm = 1'b1;
        imm32        = {instr[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        ctl.asel     = ASEL_PC;
        ctl.bsel_imm = 1'b1;
        imm32        = {instr[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctl.asel     = ASEL_PC;
        ctl.bsel_imm = 1'b1;
        imm32        = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ctl.illegal = 1'b1;
    endcase
    // Illegal entries carry a clean ADD payload so nothing downstream acts on stale fields.
    if (ctl.illegal) begin
      ctl         = '0;
      ctl.illegal = 1'b1;
      imm32       = '0;
    end
  end

  generate
    if (XLEN > 32) begin : g_sext
      assign imm = {{(XLEN-32){imm32[31]}}, imm32};
    end else begin : g_nosext
      assign imm = imm32;
    end
  endgenerate

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage: two-entry skid buffer around alu_decode_comb plus a
// saturating illegal-instruction counter. Optional macro: RV32M_EXT_EN.
module alu_decode_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_aluop,
  output logic [1:0]       out_asel,
  output logic             out_bsel_imm,
  output logic [XLEN-1:0]  out_imm,
  output logic             out_br_inv,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  dec_ctl_t          ctl_p0;
  logic [XLEN-1:0]   imm_p0;
  dec_ctl_t          ctl_p1, ctl_sk_p1;
  logic [XLEN-1:0]   imm_p1, imm_sk_p1;
  logic              vld_p1, vld_sk_p1, rdy_p1;
  logic [CNT_W-1:0]  cnt_p1;
  logic              acc, pop;

  alu_decode_comb #(.XLEN(XLEN)) u_comb (
    .instr (in_instr),
    .ctl   (ctl_p0),
    .imm   (imm_p0)
  );

  assign acc = in_valid && rdy_p1;
  assign pop = vld_p1 && out_ready;

  // ---- p0 -> p1: main/skid registers ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
      rdy_p1    <= 1'b1;
      ctl_p1    <= '0;
      imm_p1    <= '0;
      ctl_sk_p1 <= '0;
      imm_sk_p1 <= '0;
    end else if (flush) begin
      vld_p1    <= 1'b0;
      vld_sk_p1 <= 1'b0;
      rdy_p1    <= 1'b1;
    end else if (!vld_p1 || out_ready) begin
      if (vld_sk_p1) begin
        ctl_p1    <= ctl_sk_p1;
        imm_p1    <= imm_sk_p1;
        vld_p1    <= 1'b1;
        vld_sk_p1 <= 1'b0;
        rdy_p1    <= 1'b1;
      end else if (acc) begin
        ctl_p1 <= ctl_p0;
        imm_p1 <= imm_p0;
        vld_p1 <= 1'b1;
      end else begin
        vld_p1 <= 1'b0;
      end
    end else if (acc) begin
      ctl_sk_p1 <= ctl_p0;
      imm_sk_p1 <= imm_p0;
      vld_sk_p1 <= 1'b1;
      rdy_p1    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_p1 <= '0;
    else if (pop && ctl_p1.illegal)
      cnt_p1 <= sat_inc(cnt_p1);
  end

  assign in_ready     = rdy_p1;
  assign out_valid    = vld_p1;
  assign out_aluop    = ctl_p1.aluop;
  assign out_asel     = ctl_p1.asel;
  assign out_bsel_imm = ctl_p1.bsel_imm;
  assign out_imm      = imm_p1;
  assign out_br_inv   = ctl_p1.br_inv;
  assign out_illegal  = ctl_p1.illegal;
  assign illegal_cnt  = cnt_p1;

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vector table plus stall, flush,
// counter-saturation and async-reset sequences.
module tb_alu_decode_stage;
  import rv_alu_pkg::*;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_instr = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [4:0]       out_aluop;
  logic [1:0]       out_asel;
  logic             out_bsel_imm;
  logic [XLEN-1:0]  out_imm;
  logic             out_br_inv;
  logic             out_illegal;
  logic [CNT_W-1:0] illegal_cnt;

  alu_decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr     (in_instr),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_aluop    (out_aluop),
    .out_asel     (out_asel),
    .out_bsel_imm (out_bsel_imm),
    .out_imm      (out_imm),
    .out_br_inv   (out_br_inv),
    .out_illegal  (out_illegal),
    .illegal_cnt  (illegal_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  aluop;
    logic [1:0]  asel;
    logic        bsel;
    logic [31:0] imm;
    logic        inv;
    logic        ill;
  } vec_t;

  localparam int NV = 17;
  vec_t vecs[NV];

  int checks = 0;
  int errors = 0;
  int exp_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{32'h40B50533, 5'd1,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0}; // SUB
    vecs[1]  = '{32'h00B57463, 5'd9,  2'd0, 1'b0, 32'h00000008, 1'b1, 1'b0}; // BGEU
    vecs[2]  = '{32'hFFF00093, 5'd0,  2'd0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0}; // ADDI -1
    vecs[3]  = '{32'h123450B7, 5'd0,  2'd2, 1'b1, 32'h12345000, 1'b0, 1'b0}; // LUI
    vecs[4]  = '{32'h00001097, 5'd0,  2'd1, 1'b1, 32'h00001000, 1'b0, 1'b0}; // AUIPC
    vecs[5]  = '{32'h008000EF, 5'd0,  2'd1, 1'b1, 32'h00000008, 1'b0, 1'b0}; // JAL +8
    vecs[6]  = '{32'h00B52223, 5'd0,  2'd0, 1'b1, 32'h00000004, 1'b0, 1'b0}; // SW 4
    vecs[7]  = '{32'hFFC12083, 5'd0,  2'd0, 1'b1, 32'hFFFFFFFC, 1'b0, 1'b0}; // LW -4
    vecs[8]  = '{32'h40315093, 5'd7,  2'd0, 1'b1, 32'h00000403, 1'b0, 1'b0}; // SRAI
    vecs[9]  = '{32'h20315093, 5'd0,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // bad shift
    vecs[10] = '{32'h00B51463, 5'd1,  2'd0, 1'b0, 32'h00000008, 1'b1, 1'b0}; // BNE
    vecs[11] = '{32'h00B52463, 5'd0,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // branch f3=010
    vecs[12] = '{32'hFFFFFFFF, 5'd0,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // bad opcode
    vecs[13] = '{32'h40B54533, 5'd0,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // alt XOR
    vecs[14] = '{32'h00B53533, 5'd9,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0}; // SLTU
`ifdef RV32M_EXT_EN
    vecs[15] = '{32'h02B50533, 5'd10, 2'd0, 1'b0, 32'h00000000, 1'b0, 1'b0}; // MUL
`else
    vecs[15] = '{32'h02B50533, 5'd0,  2'd0, 1'b0, 32'h00000000, 1'b0, 1'b1}; // MUL off
`endif
    vecs[16] = '{32'h00008067, 5'd0,  2'd0, 1'b1, 32'h00000000, 1'b0, 1'b0}; // JALR

    // Async reset with no clock edge involved
    #2 rst_n = 1'b0;
    #1;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst illegal_cnt", illegal_cnt, 0);
    chk("rst fields", {out_aluop, out_asel, out_bsel_imm, out_imm, out_br_inv, out_illegal}, 0);
    step();
    #2 rst_n = 1'b1;
    step();

    // Decode table, streamed back to back with out_ready held high
    exp_cnt = 0;
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      chk($sformatf("v%0d in_ready", i), in_ready, 1);
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d aluop", i), out_aluop, vecs[i].aluop);
      chk($sformatf("v%0d asel", i), out_asel, vecs[i].asel);
      chk($sformatf("v%0d bsel_imm", i), out_bsel_imm, vecs[i].bsel);
      chk($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
      chk($sformatf("v%0d br_inv", i), out_br_inv, vecs[i].inv);
      chk($sformatf("v%0d illegal", i), out_illegal, vecs[i].ill);
      if (vecs[i].ill) exp_cnt++;
    end
    step();
    chk("table drained", out_valid, 0);
    chk("table illegal_cnt", illegal_cnt, exp_cnt);

    // Stall: 4 instrs, out_ready low for 3 edges
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    step();
    chk("stall A out_valid", out_valid, 1);
    chk("stall A imm", out_imm, 1);
    chk("stall in_ready after 1", in_ready, 1);
    in_instr = 32'h00200093;
    step();
    chk("stall in_ready after 2", in_ready, 0);
    chk("stall hold A", out_imm, 1);
    in_instr = 32'h00300093;
    step();
    chk("stall hold A 2", out_imm, 1);
    chk("stall in_ready held", in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("drain B", out_imm, 2);
    chk("drain in_ready", in_ready, 1);
    step();
    chk("drain C", out_imm, 3);
    in_instr = 32'h00400093;
    step();
    in_valid = 1'b0;
    chk("drain D", out_imm, 4);
    chk("drain D valid", out_valid, 1);
    step();
    chk("drain empty", out_valid, 0);

    // Flush with both entries full and input offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFFFFFFF;
    step();
    in_instr = 32'h00200093;
    step();
    chk("flush pre skid full", in_ready, 0);
    in_instr = 32'h00300093;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    chk("flush no leak 1", out_valid, 0);
    step();
    chk("flush no leak 2", out_valid, 0);
    chk("flush keeps cnt", illegal_cnt, exp_cnt);

    // Flush overrides a simultaneous input transfer
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093;
    step();
    in_instr = 32'h00500093;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush2 out_valid", out_valid, 0);
    out_ready = 1'b1;
    step();
    chk("flush2 dropped", out_valid, 0);

    // Counter saturation: 2^CNT_W+3 illegal words from a clean reset
    rst_n = 1'b0;
    #1;
    chk("rst2 cnt", illegal_cnt, 0);
    #2 rst_n = 1'b1;
    step();
    exp_cnt = 0;
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      in_valid = 1'b1;
      in_instr = 32'hFFFFFFFF;
      step();
      if (i > 0 && exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      if (i == 8) chk("sat mid cnt", illegal_cnt, exp_cnt);
    end
    in_valid = 1'b0;
    step();
    if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
    chk("sat cnt", illegal_cnt, exp_cnt);
    chk("sat all ones", illegal_cnt, {CNT_W{1'b1}});

    // Reset asserted mid-stream while stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'hFFFFFFFF;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst cnt", illegal_cnt, 0);
    chk("midrst out_valid", out_valid, 0);
    chk("midrst in_ready", in_ready, 1);
    chk("midrst illegal", out_illegal, 0);
    in_valid = 1'b0;
    step();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b1;
    in_instr = 32'h40B50533;
    step();
    in_valid = 1'b0;
    chk("post rst valid", out_valid, 1);
    chk("post rst aluop", out_aluop, 1);
    chk("post rst illegal", out_illegal, 0);
    step();
    chk("post rst drained", out_valid, 0);
    chk("post rst cnt", illegal_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
